// File: rtl/matrix_skew_feeder.sv
// Latches an N x N matrix and streams it out as 2N-1 skewed
// anti-diagonal wavefronts, one element per output lane.
module matrix_skew_feeder #(
    parameter int N      = 32,
    parameter int DATA_W = 16,
    localparam int SW    = $clog2(2*N-1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              transpose,
    input  logic [DATA_W-1:0] matrix_in [0:N-1][0:N-1],
    output logic [DATA_W-1:0] vector_out [0:N-1],
    output logic              vec_valid,
    output logic [SW-1:0]     step_idx,
    output logic              busy,
    output logic              done
);

    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [SW-1:0] LAST = SW'(2*N-2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mat_q [0:N-1][0:N-1];
    logic [DATA_W-1:0] wave  [0:N-1];
    logic [SW-1:0]     cnt_q;
    logic              mode_q;
    logic              accept, advance, last;
    int                k;
    logic [IW-1:0]     kx, ix;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        last    = (cnt_q == LAST);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    advance = 1'b1;
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane i reads diagonal offset t-i; out-of-range lanes are zero.
    always_comb begin
        k  = 0;
        kx = '0;
        ix = '0;
        for (int i = 0; i < N; i++) begin
            wave[i] = '0;
            k  = int'(cnt_q) - i;
            kx = k[IW-1:0];
            ix = IW'(i);
            if (k >= 0 && k < N) begin
                wave[i] = mode_q ? mat_q[ix][kx] : mat_q[kx][ix];
            end
        end
    end

    // Buffer is intentionally unreset; it is only read after a load.
    always_ff @(posedge clk) begin
        if (accept) mat_q <= matrix_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            vec_valid  <= 1'b0;
            step_idx   <= '0;
            done       <= 1'b0;
            vector_out <= '{default: '0};
        end else begin
            state_q   <= state_d;
            vec_valid <= advance;
            done      <= advance && last;
            if (accept) begin
                mode_q <= transpose;
                cnt_q  <= '0;
            end
            if (advance) begin
                vector_out <= wave;
                step_idx   <= cnt_q;
                cnt_q      <= cnt_q + 1'b1;
            end
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Scoreboard bench: expected wavefronts are queued at start and
// popped by monitors on every valid output of two DUT sizes.
module tb_matrix_skew_feeder;
    localparam int N  = 4;
    localparam int M  = 32;
    localparam int W  = 16;
    localparam int L4 = 2*N-1;
    localparam int L32 = 2*M-1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         en, start, transpose;
    logic [W-1:0] m_in [0:N-1][0:N-1];
    logic [W-1:0] v_out [0:N-1];
    logic         vv, busy, done;
    logic [2:0]   sidx;

    logic         en32, start32, tr32;
    logic [W-1:0] m32 [0:M-1][0:M-1];
    logic [W-1:0] v32 [0:M-1];
    logic         vv32, busy32, done32;
    logic [5:0]   sidx32;

    matrix_skew_feeder #(.N(N), .DATA_W(W)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .transpose(transpose), .matrix_in(m_in),
        .vector_out(v_out), .vec_valid(vv), .step_idx(sidx),
        .busy(busy), .done(done)
    );

    matrix_skew_feeder #(.N(M), .DATA_W(W)) u32 (
        .clk(clk), .rst_n(rst_n), .en(en32), .start(start32),
        .transpose(tr32), .matrix_in(m32),
        .vector_out(v32), .vec_valid(vv32), .step_idx(sidx32),
        .busy(busy32), .done(done32)
    );

    int vectors = 0;
    int miscompares = 0;

    int a4 [0:N-1][0:N-1];
    int a32 [0:M-1][0:M-1];

    logic [N*W-1:0] q4v[$];
    int             q4t[$];
    logic [M*W-1:0] q32v[$];
    int             q32t[$];

    logic [N*W-1:0] seen4 [0:L4-1];
    logic [W-1:0]   t62_lane31;
    int n4 = 0, n32 = 0, nd4 = 0, nd32 = 0;

    task automatic check(string name, logic [511:0] act,
                         logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pack4();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v_out[i];
        return r;
    endfunction

    function automatic logic [M*W-1:0] pack32();
        logic [M*W-1:0] r;
        for (int i = 0; i < M; i++) r[i*W +: W] = v32[i];
        return r;
    endfunction

    function automatic logic [N*W-1:0] mk4(int a, int b, int c, int d);
        return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    endfunction

    // Reference: wavefront t, lane i is A[t-i][i] (or A[i][t-i])
    function automatic logic [N*W-1:0] model4(int t, bit tr);
        logic [N*W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            int d = t - i;
            if (d >= 0 && d < N)
                r[i*W +: W] = tr ? W'(a4[i][d]) : W'(a4[d][i]);
        end
        return r;
    endfunction

    function automatic logic [M*W-1:0] model32(int t, bit tr);
        logic [M*W-1:0] r = '0;
        for (int i = 0; i < M; i++) begin
            int d = t - i;
            if (d >= 0 && d < M)
                r[i*W +: W] = tr ? W'(a32[i][d]) : W'(a32[d][i]);
        end
        return r;
    endfunction

    task automatic load4();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_in[r][c] = W'(a4[r][c]);
    endtask

    task automatic default4();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) a4[r][c] = 4*r + c + 1;
        load4();
    endtask

    task automatic start_run4(bit tr);
        load4();
        transpose = tr;
        start = 1'b1;
        for (int t = 0; t < L4; t++) begin
            q4v.push_back(model4(t, tr));
            q4t.push_back(t);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle4(int budget);
        int b = 0;
        while (busy && b < budget) begin
            tick();
            b++;
        end
        check("u4 idle within budget", 512'(busy), 512'(0));
        @(negedge clk);
        #1;
    endtask

    task automatic end_run4(string name, int base);
        check({name, " valid count"}, 512'(n4 - base), 512'(L4));
        check({name, " queue drained"}, 512'(q4t.size()), 512'(0));
    endtask

    always @(negedge clk) begin : mon4
        int t;
        logic [N*W-1:0] e;
        if (rst_n) begin
            if (done) nd4++;
            if (vv) begin
                n4++;
                check("u4 expected pending",
                      512'(q4t.size() > 0), 512'(1));
                if (q4t.size() > 0) begin
                    t = q4t.pop_front();
                    e = q4v.pop_front();
                    seen4[t] = pack4();
                    check("u4 step_idx", 512'(sidx), 512'(t));
                    check("u4 wavefront", 512'(pack4()), 512'(e));
                    check("u4 done", 512'(done), 512'(t == L4-1));
                end
            end else if (done) begin
                check("u4 stray done", 512'(done), 512'(0));
            end
        end
    end

    always @(negedge clk) begin : mon32
        int t;
        logic [M*W-1:0] e;
        if (rst_n) begin
            if (done32) nd32++;
            if (vv32) begin
                n32++;
                check("u32 expected pending",
                      512'(q32t.size() > 0), 512'(1));
                if (q32t.size() > 0) begin
                    t = q32t.pop_front();
                    e = q32v.pop_front();
                    if (t == L32-1) t62_lane31 = v32[M-1];
                    check("u32 step_idx", 512'(sidx32), 512'(t));
                    check("u32 wavefront", pack32(), e);
                    check("u32 done", 512'(done32), 512'(t == L32-1));
                end
            end else if (done32) begin
                check("u32 stray done", 512'(done32), 512'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b, ndr;
        en = 1'b1; start = 1'b0; transpose = 1'b0;
        en32 = 1'b1; start32 = 1'b0; tr32 = 1'b0;
        default4();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) m32[r][c] = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset vec_valid", 512'(vv), 512'(0));
        check("reset step_idx", 512'(sidx), 512'(0));
        check("reset busy", 512'(busy), 512'(0));
        check("reset done", 512'(done), 512'(0));
        check("reset vector_out", 512'(pack4()), 512'(0));
        check("reset u32 vector_out", pack32(), 512'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Normal run
        base = n4;
        start_run4(1'b0);
        check("busy after accept", 512'(busy), 512'(1));
        tick();
        check("first wavefront latency", 512'(vv), 512'(1));
        wait_idle4(20);
        end_run4("normal", base);
        check("normal t0", 512'(seen4[0]), 512'(mk4(1, 0, 0, 0)));
        check("normal t1", 512'(seen4[1]), 512'(mk4(5, 2, 0, 0)));
        check("normal t3", 512'(seen4[3]), 512'(mk4(13, 10, 7, 4)));
        check("normal t6", 512'(seen4[6]), 512'(mk4(0, 0, 0, 16)));
        check("normal busy after done", 512'(busy), 512'(0));
        check("normal done pulses", 512'(nd4), 512'(1));

        // Transpose run
        base = n4;
        start_run4(1'b1);
        wait_idle4(20);
        end_run4("transpose", base);
        check("transpose t1", 512'(seen4[1]), 512'(mk4(2, 5, 0, 0)));
        check("transpose t3", 512'(seen4[3]), 512'(mk4(4, 7, 10, 13)));
        check("transpose t6", 512'(seen4[6]), 512'(mk4(0, 0, 0, 16)));

        // Stall for 3 cycles after t2
        base = n4;
        start_run4(1'b0);
        tick();
        tick();
        tick();
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall vec_valid", 512'(vv), 512'(0));
            check("stall hold data", 512'(pack4()),
                  512'(mk4(9, 6, 3, 0)));
            check("stall hold step_idx", 512'(sidx), 512'(2));
        end
        en = 1'b1;
        tick();
        check("resume valid", 512'(vv), 512'(1));
        check("resume step", 512'(sidx), 512'(3));
        wait_idle4(20);
        end_run4("stall", base);

        // Start and matrix rewrite during the run are ignored
        base = n4;
        start_run4(1'b0);
        tick();
        tick();
        start = 1'b1;
        transpose = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_in[r][c] = 16'hFFFF;
        tick();
        tick();
        start = 1'b0;
        transpose = 1'b0;
        load4();
        wait_idle4(20);
        end_run4("interference", base);

        // Reset while t3 is on the outputs
        start_run4(1'b0);
        tick();
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset vec_valid", 512'(vv), 512'(0));
        check("midreset step_idx", 512'(sidx), 512'(0));
        check("midreset busy", 512'(busy), 512'(0));
        check("midreset done", 512'(done), 512'(0));
        check("midreset vector_out", 512'(pack4()), 512'(0));
        q4v.delete();
        q4t.delete();
        ndr = nd4;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("midreset no done", 512'(nd4 - ndr), 512'(0));
        base = n4;
        start_run4(1'b0);
        wait_idle4(20);
        end_run4("after reset", base);
        check("after reset t0", 512'(seen4[0]), 512'(mk4(1, 0, 0, 0)));

        // Random matrices, modes, stalls and input churn
        for (int run = 0; run < 8; run++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    a4[r][c] = int'($urandom_range(0, 65535));
            base = n4;
            en = 1'($urandom_range(0, 1));
            start_run4(1'($urandom_range(0, 1)));
            b = 0;
            while (busy && b < 200) begin
                en = 1'($urandom_range(0, 1));
                transpose = 1'($urandom_range(0, 1));
                m_in[$urandom_range(0, N-1)][$urandom_range(0, N-1)] =
                    W'($urandom);
                tick();
                b++;
            end
            en = 1'b1;
            wait_idle4(20);
            end_run4("random", base);
        end

        // Back-to-back at N=32
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                a32[r][c] = M*r + c + 1;
                m32[r][c] = W'(a32[r][c]);
            end
        base = n32;
        tr32 = 1'b0;
        start32 = 1'b1;
        for (int t = 0; t < L32; t++) begin
            q32v.push_back(model32(t, 1'b0));
            q32t.push_back(t);
        end
        tick();
        check("u32 busy run1", 512'(busy32), 512'(1));
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                a32[r][c] = int'($urandom_range(0, 65535));
                m32[r][c] = W'(a32[r][c]);
            end
        b = 0;
        while (!done32 && b < 100) begin
            tick();
            b++;
        end
        check("u32 done within budget", 512'(done32), 512'(1));
        check("u32 start at last ignored", 512'(busy32), 512'(0));
        tr32 = 1'b1;
        for (int t = 0; t < L32; t++) begin
            q32v.push_back(model32(t, 1'b1));
            q32t.push_back(t);
        end
        tick();
        start32 = 1'b0;
        tr32 = 1'b0;
        check("u32 start after done accepted", 512'(busy32), 512'(1));
        check("u32 t62 lane31", 512'(t62_lane31), 512'(1024));
        check("u32 run1 count", 512'(n32 - base), 512'(L32));
        b = 0;
        while (busy32 && b < 100) begin
            tick();
            b++;
        end
        check("u32 idle within budget", 512'(busy32), 512'(0));
        @(negedge clk);
        #1;
        check("u32 total count", 512'(n32 - base), 512'(2*L32));
        check("u32 queue drained", 512'(q32t.size()), 512'(0));
        check("u32 done pulses", 512'(nd32), 512'(2));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
